// File: rtl/lsu_bus_unit_if.sv
// Memory-side bus of the load/store unit: request handshake plus response channel.
// master = load/store unit, slave = memory or bus adapter.
interface lsu_bus_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rdata;
    logic              mem_rsp_err;

    modport master (
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err
    );
endinterface

// File: rtl/lsu_bus_unit.sv
// Multi-cycle RV32 load/store unit: width decode, lane steering, optional
// two-beat split of word-crossing accesses, per-state timeout.
module lsu_bus_unit #(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int TIMEOUT          = 16,
    parameter int TMO_W            = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_err,
    lsu_bus_unit_if.master    mem,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MIS   = 2'b01;
    localparam logic [1:0] ERR_FAULT = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    function automatic logic [3:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
    endfunction

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       beat0_q;

    logic              latch;
    logic              resp_load;
    logic [1:0]        resp_err_d;
    logic [31:0]       resp_data_d;
    logic              tmo_hit;

    logic [1:0]        off_q;
    logic [7:0]        mask8;
    logic [63:0]       image;
    logic              crossing;
    logic [ADDR_W-1:0] word0, word1;
    logic [31:0]       rd_lo, rd_hi, rd_v, load_val;

    assign off_q    = addr_q[1:0];
    // The strobe mask spilling into the upper nibble is exactly the word-crossing case.
    assign mask8    = {4'b0000, lane_mask(f3_q[1:0])} << off_q;
    assign crossing = |mask8[7:4];
    assign image    = {32'h0, wdata_q} << {off_q, 3'b000};
    assign word0    = {addr_q[ADDR_W-1:2], 2'b00};
    assign word1    = word0 + ADDR_W'(4);
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);

    always_comb begin
        mem.mem_req_valid = 1'b0;
        mem.mem_addr      = '0;
        mem.mem_we        = 1'b0;
        mem.mem_wstrb     = '0;
        mem.mem_wdata     = '0;
        case (state_q)
            S_ISSUE0: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_addr      = word0;
                mem.mem_we        = we_q;
                if (we_q) begin
                    mem.mem_wstrb = mask8[3:0];
                    mem.mem_wdata = image[31:0];
                end
            end
            S_ISSUE1: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_addr      = word1;
                mem.mem_we        = we_q;
                if (we_q) begin
                    mem.mem_wstrb = mask8[7:4];
                    mem.mem_wdata = image[63:32];
                end
            end
            default: ;
        endcase
    end

    // The final beat's data is taken straight off the bus so the result lands in RESP.
    always_comb begin
        rd_lo = (state_q == S_WAIT1) ? beat0_q : mem.mem_rdata;
        rd_hi = (state_q == S_WAIT1) ? mem.mem_rdata : '0;
        rd_v  = 32'({rd_hi, rd_lo} >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  load_val = {{24{rd_v[7]}}, rd_v[7:0]};
            3'b001:  load_val = {{16{rd_v[15]}}, rd_v[15:0]};
            3'b010:  load_val = rd_v;
            3'b100:  load_val = {24'h0, rd_v[7:0]};
            3'b101:  load_val = {16'h0, rd_v[15:0]};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        resp_load   = 1'b0;
        resp_err_d  = ERR_OK;
        resp_data_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    latch = 1'b1;
                    if (!f3_legal(req_we, req_funct3)) begin
                        state_d    = S_RESP;
                        resp_load  = 1'b1;
                        resp_err_d = ERR_ILL;
                    end else if (!SPLIT_MISALIGNED &&
                                 is_misaligned(req_funct3[1:0], req_addr[1:0])) begin
                        state_d    = S_RESP;
                        resp_load  = 1'b1;
                        resp_err_d = ERR_MIS;
                    end else begin
                        state_d = S_ISSUE0;
                    end
                end
            end
            S_ISSUE0, S_ISSUE1: begin
                if (mem.mem_req_ready) begin
                    state_d = (state_q == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
                end else if (tmo_hit) begin
                    state_d    = S_RESP;
                    resp_load  = 1'b1;
                    resp_err_d = ERR_FAULT;
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (mem.mem_rsp_valid) begin
                    if (mem.mem_rsp_err) begin
                        state_d    = S_RESP;
                        resp_load  = 1'b1;
                        resp_err_d = ERR_FAULT;
                    end else if (crossing && (state_q == S_WAIT0)) begin
                        state_d = S_ISSUE1;
                    end else begin
                        state_d     = S_RESP;
                        resp_load   = 1'b1;
                        resp_data_d = we_q ? '0 : load_val;
                    end
                end else if (tmo_hit) begin
                    state_d    = S_RESP;
                    resp_load  = 1'b1;
                    resp_err_d = ERR_FAULT;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            beat0_q   <= '0;
            resp_data <= '0;
            resp_err  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + TMO_W'(1);
            if (latch) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state_q == S_WAIT0) && mem.mem_rsp_valid) begin
                beat0_q <= mem.mem_rdata;
            end
            if (resp_load) begin
                resp_data <= resp_data_d;
                resp_err  <= resp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Directed bench for lsu_bus_unit: vector table through a split/timeout instance,
// hand sequences for bus error, timeouts, reset abort and a no-split instance.
module tb_lsu_bus_unit;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, busy;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    logic        r0_valid, r0_ready, r0_we;
    logic [2:0]  r0_funct3;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_resp_valid, r0_busy;
    logic [31:0] r0_resp_data;
    logic [1:0]  r0_resp_err;

    lsu_bus_unit_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_bus_unit_if #(.ADDR_W(ADDR_W)) bus0 ();

    lsu_bus_unit #(.ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1'b1), .TIMEOUT(8), .TMO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem(bus.master), .busy(busy)
    );

    lsu_bus_unit #(.ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1'b0), .TIMEOUT(16), .TMO_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
        .req_funct3(r0_funct3), .req_addr(r0_addr), .req_wdata(r0_wdata),
        .resp_valid(r0_resp_valid), .resp_data(r0_resp_data), .resp_err(r0_resp_err),
        .mem(bus0.master), .busy(r0_busy)
    );

    assign bus0.mem_req_ready = 1'b1;
    assign bus0.mem_rsp_valid = 1'b0;
    assign bus0.mem_rdata     = 32'h0;
    assign bus0.mem_rsp_err   = 1'b0;

    // Bus model: accept when ready_en, answer one cycle after each handshake.
    logic        ready_en, rsp_en, err_inj, stale_rsp;
    logic        hs_prev;
    logic [31:0] hs_addr;
    logic [31:0] mem_model [logic [31:0]];
    int          beat_total = 0;
    logic [31:0] lg_addr  [256];
    logic [31:0] lg_wdata [256];
    logic [3:0]  lg_strb  [256];
    logic        lg_we    [256];

    assign bus.mem_req_ready = ready_en;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            lg_addr[8'(beat_total)]  = bus.mem_addr;
            lg_wdata[8'(beat_total)] = bus.mem_wdata;
            lg_strb[8'(beat_total)]  = bus.mem_wstrb;
            lg_we[8'(beat_total)]    = bus.mem_we;
            beat_total = beat_total + 1;
            hs_prev = 1'b1;
            hs_addr = bus.mem_addr;
        end else begin
            hs_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #2;
        bus.mem_rsp_valid = (hs_prev && rsp_en) || stale_rsp;
        bus.mem_rsp_err   = hs_prev && rsp_en && err_inj;
        bus.mem_rdata     = (hs_prev && rsp_en) ? mem_rd(hs_addr) : 32'h0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [1:0] err,
                         output logic [31:0] data, output int lat, output int reqc,
                         output int first, output logic tail);
        first      = beat_total;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat  = -1;
        reqc = 0;
        err  = 2'bxx;
        data = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.mem_req_valid) reqc++;
            if (resp_valid) begin
                lat  = k;
                err  = resp_err;
                data = resp_data;
                break;
            end
        end
        @(negedge clk);
        tail = resp_valid;
    endtask

    task automatic do_op0(input logic [2:0] f3, input logic [31:0] addr,
                          output logic [1:0] err, output logic [31:0] data,
                          output int lat, output int reqc);
        r0_valid  = 1'b1;
        r0_we     = 1'b0;
        r0_funct3 = f3;
        r0_addr   = addr;
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        lat  = -1;
        reqc = 0;
        err  = 2'bxx;
        data = 32'hx;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus0.mem_req_valid) reqc++;
            if (r0_resp_valid) begin
                lat  = k;
                err  = r0_resp_err;
                data = r0_resp_data;
                break;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, m0, m1, a0, a1;
        logic [1:0]  err;
        logic [31:0] data;
        int          lat, beats;
        logic [3:0]  s0;
        logic [31:0] w0;
        logic [3:0]  s1;
        logic [31:0] w1;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [1:0]  err;
        logic [31:0] data;
        int          lat, reqc, first, nb, bad;
        logic        tail;
        logic [7:0]  i0, i1;

        //          we    f3      addr          wdata         m0            m1            a0            a1            err    data          lat beats s0       w0            s1       w1
        vecs[0]  = '{1'b1, 3'b010, 32'h00001000, 32'hDEADBEEF, 32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h0,        3, 1, 4'b1111, 32'hDEADBEEF, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h00001003, 32'h0,        32'h80FF0000, 32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'hFFFFFF80, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h00001003, 32'h0,        32'h80FF0000, 32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h00000080, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h00001002, 32'h0,        32'h80FF0000, 32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'hFFFF80FF, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b010, 32'h00001002, 32'h0,        32'h44332211, 32'h88776655, 32'h00001000, 32'h00001004, 2'b00, 32'h66554433, 5, 2, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[5]  = '{1'b1, 3'b001, 32'h00001003, 32'h0000ABCD, 32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h0,        5, 2, 4'b1000, 32'hCD000000, 4'b0001, 32'h000000AB};
        vecs[6]  = '{1'b0, 3'b011, 32'h00001000, 32'h0,        32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b11, 32'h0,        1, 0, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 3'b100, 32'h00001000, 32'h00000001, 32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b11, 32'h0,        1, 0, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 3'b101, 32'h00002006, 32'h0,        32'hBEEF1234, 32'h0,        32'h00002004, 32'h00002008, 2'b00, 32'h0000BEEF, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 3'b001, 32'h00002001, 32'h0,        32'h11A58722, 32'h0,        32'h00002000, 32'h00002004, 2'b00, 32'hFFFFA587, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[10] = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        32'hCAFEF00D, 32'h01234567, 32'hFFFFFFFC, 32'h00000000, 2'b00, 32'h4567CAFE, 5, 2, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b1, 3'b000, 32'h00001001, 32'h123456A5, 32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h0,        3, 1, 4'b0010, 32'h3456A500, 4'b0000, 32'h0};
        vecs[12] = '{1'b1, 3'b010, 32'h00001003, 32'h11223344, 32'h0,        32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h0,        5, 2, 4'b1000, 32'h44000000, 4'b0111, 32'h00112233};
        vecs[13] = '{1'b0, 3'b000, 32'h00001000, 32'h0,        32'h0000007F, 32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h0000007F, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'h00001000, 32'h0,        32'h80000001, 32'h0,        32'h00001000, 32'h00001004, 2'b00, 32'h80000001, 3, 1, 4'b0000, 32'h0,        4'b0000, 32'h0};
        vecs[15] = '{1'b0, 3'b101, 32'h00001003, 32'h0,        32'hAA000000, 32'h000000BB, 32'h00001000, 32'h00001004, 2'b00, 32'h0000BBAA, 5, 2, 4'b0000, 32'h0,        4'b0000, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        r0_valid = 1'b0; r0_we = 1'b0; r0_funct3 = '0; r0_addr = '0; r0_wdata = '0;
        ready_en = 1'b1; rsp_en = 1'b1; err_inj = 1'b0; stale_rsp = 1'b0;
        hs_prev = 1'b0; hs_addr = '0;

        repeat (2) @(negedge clk);
        check("reset ctrl", {req_ready, busy, resp_valid, bus.mem_req_valid, bus.mem_we, resp_err, bus.mem_wstrb},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000});
        check("reset data", {resp_data, bus.mem_addr, bus.mem_wdata}, 96'h0);
        check("reset dut0", {r0_ready, r0_busy, r0_resp_valid, bus0.mem_req_valid}, 4'b1000);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            mem_model[v.a0] = v.m0;
            mem_model[v.a1] = v.m1;
            do_op(v.we, v.f3, v.addr, v.wdata, err, data, lat, reqc, first, tail);
            nb = beat_total - first;
            i0 = 8'(first);
            i1 = 8'(first + 1);
            check($sformatf("v%0d err", i), err, v.err);
            check($sformatf("v%0d data", i), data, v.data);
            check($sformatf("v%0d latency", i), lat, v.lat);
            check($sformatf("v%0d beats", i), nb, v.beats);
            check($sformatf("v%0d resp pulse", i), tail, 1'b0);
            if (nb > 0 && v.beats > 0) begin
                check($sformatf("v%0d beat0 addr/we/strb", i), {lg_addr[i0], lg_we[i0], lg_strb[i0]}, {v.a0, v.we, v.s0});
                if (v.we) check($sformatf("v%0d beat0 wdata", i), lg_wdata[i0], v.w0);
            end
            if (nb > 1 && v.beats > 1) begin
                check($sformatf("v%0d beat1 addr/we/strb", i), {lg_addr[i1], lg_we[i1], lg_strb[i1]}, {v.a1, v.we, v.s1});
                if (v.we) check($sformatf("v%0d beat1 wdata", i), lg_wdata[i1], v.w1);
            end
        end

        // Bus error on the first beat of a crossing load: second beat never issued.
        mem_model[32'h1000] = 32'h44332211;
        err_inj = 1'b1;
        do_op(1'b0, 3'b010, 32'h00001002, 32'h0, err, data, lat, reqc, first, tail);
        err_inj = 1'b0;
        check("bus err resp", {err, data}, {2'b10, 32'h0});
        check("bus err latency", lat, 3);
        check("bus err beats", beat_total - first, 1);

        // Response never arrives: eight cycles in WAIT0.
        rsp_en = 1'b0;
        do_op(1'b0, 3'b010, 32'h00001000, 32'h0, err, data, lat, reqc, first, tail);
        check("wait timeout resp", {err, data}, {2'b10, 32'h0});
        check("wait timeout latency", lat, 10);
        check("wait timeout req cycles", reqc, 1);
        rsp_en = 1'b1;

        // Request never accepted: eight cycles in ISSUE0 with the request held.
        ready_en = 1'b0;
        do_op(1'b1, 3'b010, 32'h00001000, 32'h12345678, err, data, lat, reqc, first, tail);
        check("issue timeout resp", {err, data}, {2'b10, 32'h0});
        check("issue timeout latency", lat, 9);
        check("issue timeout req cycles", reqc, 8);
        check("issue timeout beats", beat_total - first, 0);
        ready_en = 1'b1;

        // Asynchronous reset while in WAIT0, then a stale bus response.
        rsp_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset busy", {busy, bus.mem_req_valid}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("async reset", {req_ready, busy, bus.mem_req_valid}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        stale_rsp = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            stale_rsp = 1'b0;
            if (resp_valid || busy) bad++;
        end
        check("stale rsp ignored", bad, 0);
        rsp_en = 1'b1;

        mem_model[32'h1000] = 32'h5A5A0F0F;
        do_op(1'b0, 3'b010, 32'h00001000, 32'h0, err, data, lat, reqc, first, tail);
        check("post-reset lw", {err, data}, {2'b00, 32'h5A5A0F0F});
        check("post-reset latency", lat, 3);

        // No-split instance.
        do_op0(3'b010, 32'h00001002, err, data, lat, reqc);
        check("nosplit mis resp", {err, data}, {2'b01, 32'h0});
        check("nosplit mis latency", lat, 1);
        check("nosplit mis no bus", reqc, 0);
        do_op0(3'b011, 32'h00001000, err, data, lat, reqc);
        check("nosplit ill resp", {err, data}, {2'b11, 32'h0});
        check("nosplit ill latency", lat, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
